// File: rtl/pwm_output_ctrl.sv
// rtl/pwm_output_ctrl.sv - 16 user outputs, each forced low, static high or driven by one shared PWM
// Optional PWM_SHADOW_EN: duty is latched only at period boundaries so no pulse is ever truncated.
module pwm_output_ctrl #(
   parameter int unsigned CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [7:0] CNT_LAST = 8'd254;

   logic [PW-1:0] prescaler_q, prescaler_d;
   logic [7:0]    pwm_cnt_q, pwm_cnt_d;
   logic [15:0]   out_q, out_d;
   logic          period_start_q, period_start_d;
   logic          tick;
   logic          period_end;
   logic          pwm_level;
   logic [7:0]    duty_eff;
   logic [15:0]   en_out;
   logic [15:0]   en_pwm;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick       = (prescaler_q == PRESC_LAST);
   assign period_end = tick && (pwm_cnt_q == CNT_LAST);

`ifdef PWM_SHADOW_EN
   logic [7:0] duty_shadow_q, duty_shadow_d;

   always_comb begin
      duty_shadow_d = duty_shadow_q;
      if (period_end) begin
         duty_shadow_d = pwm_duty_cycle;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_shadow_q <= 8'h00;
      end else begin
         duty_shadow_q <= duty_shadow_d;
      end
   end

   assign duty_eff = duty_shadow_q;
`else
   assign duty_eff = pwm_duty_cycle;
`endif

   // Counter stops at 254 so duty 0xFF compares true on every tick of the period.
   assign pwm_level = (pwm_cnt_q < duty_eff);

   always_comb begin
      prescaler_d    = prescaler_q + PW'(1);
      pwm_cnt_d      = pwm_cnt_q;
      period_start_d = period_end;
      if (tick) begin
         prescaler_d = '0;
         pwm_cnt_d   = period_end ? 8'd0 : pwm_cnt_q + 8'd1;
      end
      out_d = en_out & (~en_pwm | {16{pwm_level}});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler_q    <= '0;
         pwm_cnt_q      <= 8'd0;
         out_q          <= 16'h0000;
         period_start_q <= 1'b0;
      end else begin
         prescaler_q    <= prescaler_d;
         pwm_cnt_q      <= pwm_cnt_d;
         out_q          <= out_d;
         period_start_q <= period_start_d;
      end
   end

   assign out          = out_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_ctrl.sv
// tb/tb_pwm_output_ctrl.sv - directed table and sequence bench for pwm_output_ctrl (CLK_DIV 1 and 4)
module tb_pwm_output_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] en_out, en_pwm;
   logic [7:0]  duty;
   logic [15:0] out1, out4;
   logic        ps1, ps4;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   pwm_output_ctrl #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
   );

   pwm_output_ctrl #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out4), .period_start(ps4)
   );

   typedef struct {
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [15:0] exp_out;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_ps(input bit use4, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if ((use4 ? ps4 : ps1) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int hi, lo, bad, psn, n, cur, nxt, first_ps, exp_cur, exp_r4, exp_r5;

      vecs[0] = '{16'h00FF, 16'h0000, 16'h00FF};
      vecs[1] = '{16'h0000, 16'h0000, 16'h0000};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
      vecs[4] = '{16'hA5A5, 16'h0F0F, 16'hA0A0};
      vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000};
      vecs[6] = '{16'h1234, 16'h0000, 16'h1234};
      vecs[7] = '{16'hFF00, 16'h00FF, 16'hFF00};

      rst_n  = 1'b0;
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      duty   = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_out1", out1, 16'h0000);
         chk("reset_ps1", ps1, 1'b0);
         chk("reset_out4", out4, 16'h0000);
         chk("reset_ps4", ps4, 1'b0);
      end

      // duty 0 keeps the PWM level low in both builds, so table results are static
      rst_n = 1'b1;
      duty  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         en_out = vecs[i].en_out;
         en_pwm = vecs[i].en_pwm;
         @(negedge clk);
         chk($sformatf("vec%0d_out1", i), out1, vecs[i].exp_out);
         chk($sformatf("vec%0d_out4", i), out4, vecs[i].exp_out);
      end

      en_out = 16'hFFFF;
      en_pwm = 16'h0001;
      duty   = 8'h80;
      repeat (300) @(negedge clk);
      hi = 0; bad = 0; psn = 0;
      for (int k = 0; k < 255; k++) begin
         @(negedge clk);
         hi  += int'(out1[0]);
         bad += (out1[15:1] != 15'h7FFF) ? 1 : 0;
         psn += int'(ps1);
      end
      chk("duty80_high_clks", hi, 128);
      chk("duty80_upper_not_high", bad, 0);
      chk("ps_per_period", psn, 1);
      wait_ps(1'b0, 300, n);
      wait_ps(1'b0, 300, n);
      chk("ps_spacing", n, 255);

      duty = 8'h00;
      repeat (300) @(negedge clk);
      hi = 0;
      for (int k = 0; k < 510; k++) begin
         @(negedge clk);
         hi += int'(out1[0]);
      end
      chk("duty00_high_clks", hi, 0);

      duty = 8'hFF;
      repeat (300) @(negedge clk);
      lo = 0;
      for (int k = 0; k < 510; k++) begin
         @(negedge clk);
         lo += int'(!out1[0]);
      end
      chk("dutyFF_low_clks", lo, 0);

      // After period_start, the k-th following sample reflects pwm_cnt == k
      duty = 8'h40;
      wait_ps(1'b0, 300, n);
      wait_ps(1'b0, 300, n);
      chk("sync_ps_found", n, 255);
      cur = 0;
      for (int k = 0; k < 255; k++) begin
         @(negedge clk);
         cur += int'(out1[0]);
         if (k == 254) chk("shadow_ps_cur_end", ps1, 1'b1);
         if (k == 100) duty = 8'hC0;
      end
      nxt = 0;
      for (int k = 0; k < 255; k++) begin
         @(negedge clk);
         nxt += int'(out1[0]);
         if (k == 254) chk("shadow_ps_nxt_end", ps1, 1'b1);
      end
`ifdef PWM_SHADOW_EN
      exp_cur = 64;
`else
      exp_cur = 64 + (191 - 101 + 1);
`endif
      chk("duty_change_cur_period", cur, exp_cur);
      chk("duty_change_next_period", nxt, 192);

      en_out = 16'hFFFF;
      en_pwm = 16'h0001;
      duty   = 8'h01;
      wait_ps(1'b1, 1100, n);
      wait_ps(1'b1, 1100, n);
      chk("div4_ps_spacing", n, 1020);
      repeat (600) @(negedge clk);
      chk("div4_out_at_cnt150", out4, 16'hFFFE);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out4", out4, 16'h0000);
      chk("midrst_ps4", ps4, 1'b0);
      rst_n = 1'b1;
`ifdef PWM_SHADOW_EN
      exp_r4 = 16'hFFFE;
      exp_r5 = 16'hFFFE;
`else
      exp_r4 = 16'hFFFF;
      exp_r5 = 16'hFFFE;
`endif
      first_ps = -1;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         if (i == 1) chk("midrst_first_clk_out4", out4[15:1], 15'h7FFF);
         if (i == 4) chk("midrst_cnt0_last_clk", out4, exp_r4);
         if (i == 5) chk("midrst_first_tick", out4, exp_r5);
         if (ps4 === 1'b1) begin
            first_ps = i;
            break;
         end
      end
      chk("midrst_first_ps_delay", first_ps, 1020);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
